// File: rtl/regctr_sequencer_if.sv
// Handshake and feedback bundle between the run controller, its requester and the 3-bit counter.
// The master side issues run requests and returns counter feedback. The slave side is the sequencer.
interface regctr_sequencer_if #(
  parameter int STEP_W = 8
);
  logic              start;
  logic [STEP_W-1:0] steps;
  logic              abort;
  logic              q2;
  logic              q1;
  logic              q0;
  logic              clk_en;
  logic              ready;
  logic              busy;
  logic              done;
  logic              mismatch;
  logic [STEP_W-1:0] remaining;

  modport master (
    output start, steps, abort, q2, q1, q0,
    input  clk_en, ready, busy, done, mismatch, remaining
  );

  modport slave (
    input  start, steps, abort, q2, q1, q0,
    output clk_en, ready, busy, done, mismatch, remaining
  );
endinterface

// File: rtl/regctr_sequencer.sv
// Run controller for a 3-bit register counter: issues N prescaled clk_en pulses,
// checks each increment against the q2..q0 feedback and signals completion.
module regctr_sequencer #(
  parameter int CNT_W  = 3,
  parameter int DIV    = 1,
  parameter int STEP_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  regctr_sequencer_if.slave   bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  exp_q, exp_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              clk_en_q, clk_en_d;
  logic              chk_q, chk_d;
  logic              mm_q, mm_d;
  logic [CNT_W-1:0]  fb;

  assign fb = CNT_W'({bus.q2, bus.q1, bus.q0});

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    exp_d    = exp_q;
    div_d    = div_q;
    clk_en_d = 1'b0;
    chk_d    = clk_en_q;
    mm_d     = mm_q;

    // The counter steps on the edge that ends an enable cycle; the model follows on the same edge
    // and the feedback is compared one cycle later.
    if (clk_en_q) exp_d = exp_q + CNT_W'(1);
    if (chk_q && (fb != exp_q)) mm_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d = bus.steps;
          exp_d = fb;
          mm_d  = 1'b0;
          div_d = '0;
          if (bus.steps == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            // The accepting edge is the first prescaler tick, so DIV=1 enables in cycle 1.
            if (DIV == 1) begin
              clk_en_d = 1'b1;
              rem_d    = bus.steps - STEP_W'(1);
            end else begin
              div_d = DIV_W'(1);
            end
          end
        end
      end
      S_RUN: begin
        if (bus.abort || (rem_q == '0)) begin
          state_d = S_CHECK;
          div_d   = '0;
        end else if (div_q == DIV_W'(DIV - 1)) begin
          clk_en_d = 1'b1;
          rem_d    = rem_q - STEP_W'(1);
          div_d    = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an async clear, so clk_en drops the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      exp_q    <= '0;
      div_q    <= '0;
      clk_en_q <= 1'b0;
      chk_q    <= 1'b0;
      mm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      exp_q    <= exp_d;
      div_q    <= div_d;
      clk_en_q <= clk_en_d;
      chk_q    <= chk_d;
      mm_q     <= mm_d;
    end
  end

  assign bus.clk_en    = clk_en_q;
  assign bus.ready     = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mismatch  = mm_q;
  assign bus.remaining = rem_q;

endmodule
